// File: rtl/hr_pkg.sv
// Shared constants and elaboration-time helpers for the heart-rate measurement path.
// Window length and rate scaling are derived here so every block agrees on them.
package hr_pkg;

  localparam int unsigned CLK_HZ_DEF  = 100_000_000;
  localparam int unsigned BPM_MAX_DEF = 180;

  // Bit width needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic longint unsigned window_ticks(input longint unsigned clk_hz,
                                                   input int unsigned window_s);
    return clk_hz * longint'(window_s);
  endfunction

  // Factor that turns beats-per-window into beats-per-minute.
  function automatic int unsigned window_mult(input int unsigned window_s);
    return 60 / window_s;
  endfunction

endpackage

// File: rtl/pulse_conditioner.sv
// Sensor pulse front end: two-flop synchronizer, stability debounce and a
// single-cycle strobe on each accepted rising edge.
module pulse_conditioner
  import hr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic level,
  output logic beat
);

  localparam int unsigned CW = clog2(DEBOUNCE_CYC);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          level_d_reg;
  logic          beat_reg;
  logic [CW-1:0] stable_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= pulse_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive samples that disagree with the accepted level; a sample
  // that agrees again means the change was a glitch, so the run starts over.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg      <= 1'b0;
      stable_cnt_reg <= '0;
    end else if (sync2_reg == level_reg) begin
      stable_cnt_reg <= '0;
    end else if (stable_cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
      level_reg      <= sync2_reg;
      stable_cnt_reg <= '0;
    end else begin
      stable_cnt_reg <= stable_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_reg <= 1'b0;
      beat_reg    <= 1'b0;
    end else begin
      level_d_reg <= level_reg;
      beat_reg    <= level_reg & ~level_d_reg;
    end
  end

  assign level = level_reg;
  assign beat  = beat_reg;

endmodule

// File: rtl/beat_counter.sv
// Heart-rate measurement datapath: window timer, saturating beat counter,
// BPM scaling with sticky over-rate flag, and capture register for the display.
module beat_counter
  import hr_pkg::*;
#(
  parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
  parameter int unsigned WINDOW_S     = 60,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned BPM_MAX      = BPM_MAX_DEF,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             en_count,
  input  logic             clear,
  input  logic             en_cap,
  output logic             end_count,
  output logic             overflow,
  output logic [CNT_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             beat
);

  localparam longint unsigned TICKS = window_ticks(CLK_HZ, WINDOW_S);
  localparam int unsigned     TW    = clog2(TICKS);
  localparam int unsigned     MULT  = window_mult(WINDOW_S);
  localparam int unsigned     SW    = CNT_W + 6;

  logic             beat_int;
  logic [TW-1:0]    timer_reg;
  logic             window_done_reg;
  logic             end_count_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic [CNT_W-1:0] bpm_reg;
  logic             bpm_valid_reg;

  logic             counting;
  logic             last_tick;
  logic [SW-1:0]    scaled;
  logic [CNT_W-1:0] scaled_sat;

  pulse_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_cond (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .level   (),
    .beat    (beat_int)
  );

  assign counting   = en_count & ~window_done_reg;
  assign last_tick  = counting && (timer_reg == TW'(TICKS - 1));
  assign scaled     = SW'(count_reg) * SW'(MULT);
  assign scaled_sat = (scaled > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : scaled[CNT_W-1:0];

  // Capture sits outside the clear branch so a simultaneous clear still
  // captures the count as it stood before being zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      bpm_reg       <= '0;
      bpm_valid_reg <= 1'b0;
    end else if (en_cap) begin
      bpm_reg       <= scaled_sat;
      bpm_valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg       <= '0;
      window_done_reg <= 1'b0;
      end_count_reg   <= 1'b0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else if (clear) begin
      timer_reg       <= '0;
      window_done_reg <= 1'b0;
      end_count_reg   <= 1'b0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      end_count_reg <= last_tick;
      if (counting && !last_tick) timer_reg <= timer_reg + 1'b1;
      if (last_tick) window_done_reg <= 1'b1;
      if (counting && beat_int && (count_reg != {CNT_W{1'b1}})) count_reg <= count_reg + 1'b1;
      if (scaled > SW'(BPM_MAX)) overflow_reg <= 1'b1;
    end
  end

  assign end_count = end_count_reg;
  assign overflow  = overflow_reg;
  assign bpm       = bpm_reg;
  assign bpm_valid = bpm_valid_reg;
  assign beat      = beat_int;

endmodule

// File: doc/beat_counter.md
Name: beat_counter

Overview:
Measurement datapath that sits next to the heart-rate control FSM. It conditions the raw sensor pulse, times the measurement window and counts beats while the FSM enables counting. It reports end of window (end_count) and over-rate (overflow) back to the FSM, and captures the scaled BPM for the display stage when the FSM asserts en_cap.

Parameters:
CLK_HZ, 100_000_000, clk frequency in Hz
WINDOW_S, 60, measurement window in seconds; must divide 60
CNT_W, 8, width of beat counter and bpm output
BPM_MAX, 180, scaled rate above which overflow asserts
DEBOUNCE_CYC, 1_000_000, consecutive stable samples needed to accept a pulse level change

Ports:
clk  in  1  clock
rst  in  1  reset
pulse_in  in  1  raw sensor pulse, asynchronous to clk
en_count  in  1  from FSM: enables window timer and beat counting
clear  in  1  from FSM: zeroes timer, counter, window flag and overflow
en_cap  in  1  from FSM: capture scaled count into bpm
end_count  out  1  one-cycle strobe: window elapsed
overflow  out  1  level: scaled count > BPM_MAX
bpm  out  CNT_W  last captured beats-per-minute
bpm_valid  out  1  bpm holds a captured value
beat  out  1  one-cycle strobe per accepted pulse (LED/debug)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst=1 forces all outputs and internal state to 0.
- Priority: rst > clear > en_cap/en_count activity.
- Pulse conditioning:
  - 2-FF synchronizer on pulse_in.
  - Debounce: the debounced level changes only after DEBOUNCE_CYC consecutive identical synchronized samples. Any differing sample restarts the stability count.
  - beat pulses for 1 cycle on each rising edge of the debounced level.
  - Latency from a clean pulse_in rise to beat: 2 + DEBOUNCE_CYC + 1 cycles.
  - Conditioning runs regardless of en_count and clear; only rst resets it.
- Window timer:
  - TICKS = CLK_HZ*WINDOW_S. Timer width = clog2(TICKS).
  - Advances once per cycle with en_count=1 and window_done=0.
  - en_count=0 pauses the timer (holds its value).
  - On the TICKS-th enabled cycle: set window_done. end_count is registered and goes high for exactly the following cycle.
  - While window_done=1, the timer stops and no further end_count is issued until clear.
- Beat counter:
  - Increments on beat when en_count=1 and window_done=0.
  - A beat in the same cycle as the TICKS-th enabled cycle is counted.
  - Saturates at 2^CNT_W-1; never wraps.
- Scaling:
  - MULT = 60/WINDOW_S. scaled = count*MULT, computed at width CNT_W+6.
  - scaled is saturated to 2^CNT_W-1 when presented to bpm.
- overflow:
  - Registered; sets the cycle after scaled > BPM_MAX first holds (unsaturated compare).
  - Sticky until clear or rst.
- Capture:
  - On each en_cap cycle, bpm <= saturated scaled and bpm_valid <= 1. Multi-cycle en_cap is harmless because the count is static.
  - en_cap together with clear in the same cycle: capture uses the pre-clear count.
- clear:
  - Zeroes timer, count, window_done and overflow in the next cycle.
  - Does NOT touch bpm or bpm_valid, so the display keeps the last reading during the next measurement.
- Reset mid-window: everything returns to 0; no end_count is produced.
- Held clear: the block stays idle; beat still toggles on pulses but nothing is counted.

Decomposition:
- Shared package hr_pkg:
  - CLK_HZ default
  - TICKS/MULT derivation function
  - clog2 helper
  - BPM_MAX default
- Sub-module pulse_conditioner (synchronizer + debounce + rising-edge detect; ports clk, rst, pulse_in, level, beat), instantiated once.
- Timer, counter, scaling and capture stay in beat_counter.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=100, WINDOW_S=6 (MULT=10, TICKS=600), DEBOUNCE_CYC=3, BPM_MAX=50, CNT_W=8.
1. Reset: rst high 5 cycles with pulse_in toggling -> all outputs 0; beat stays 0 for 6 cycles after release.
2. Nominal: clear 1 cycle, then en_count high; 4 clean pulses of 10 cycles each -> end_count high on exactly cycle 601 after en_count rise, single cycle. en_cap 2 cycles -> bpm=40, bpm_valid=1, overflow=0.
3. Over-rate: 6 pulses -> overflow rises the cycle after the 6th beat counts (scaled 60>50) and stays high through end_count. A subsequent clear drops it next cycle.
4. Debounce: 2-cycle glitches on pulse_in -> no beat, count unchanged. A 4-cycle pulse -> exactly one beat, 6 cycles after the rise.
5. Saturation: 30 pulses -> count=30, scaled 300; after en_cap, bpm=255, overflow=1.
6. Pause and clear: drop en_count for 100 cycles mid-window -> end_count is delayed by exactly 100 cycles. Clear at cycle 300 of a second window -> count=0, bpm keeps the prior value 40, bpm_valid stays 1.
